kuznechik_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one kuznechik_cipher core among N requesters.
- Accepts 128-bit blocks on per-requester valid/ready ports and drives the core's start/release handshake.
- Captures the ciphertext and returns it, tagged with the requester index, on a single response port with backpressure.
- Sits between the bus-side clients and the cipher core; it is the only agent that drives the core.

---
 rtl/kuznechik_arbiter.sv | 130 +++++++++++++
 tb/tb_kuznechik_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kuznechik_arbiter.sv
// Round-robin arbiter and sequencer that shares one kuznechik_cipher core
// among N_REQ requesters and returns tagged ciphertext on one response port.
module kuznechik_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  logic [128*N_REQ-1:0]       req_data_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [127:0]               resp_data_o,
    output logic [$clog2(N_REQ)-1:0]   resp_id_o,
    output logic                       err_o,
    output logic                       core_req_o,
    output logic                       core_ack_o,
    output logic [127:0]               core_data_o,
    input  logic                       core_busy_i,
    input  logic                       core_valid_i,
    input  logic [127:0]               core_data_i
);

    localparam int unsigned BW = 128;
    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {
        IDLE, GRANT, START, WAIT_BUSY, RUN, RELEASE, CAPTURE, RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_q;
    logic [IW-1:0]    win_q;
    logic [IW-1:0]    win_c;
    logic             any_c;
    logic [TW-1:0]    timer_q;
    logic             waiting_c;
    logic             timeout_c;
    logic [N_REQ-1:0] ready_d;
    logic             core_req_d;
    logic             resp_valid_d;

    assign core_ack_o = 1'b0;

    // Round-robin scan starting at the rr pointer; first valid requester wins.
    always_comb begin
        win_c = '0;
        any_c = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any_c && req_valid_i[IW'((32'(rr_q) + i) % N_REQ)]) begin
                any_c = 1'b1;
                win_c = IW'((32'(rr_q) + i) % N_REQ);
            end
        end
    end

    assign waiting_c = (state_q == WAIT_BUSY) || (state_q == RUN) || (state_q == CAPTURE);
    assign timeout_c = waiting_c && (timer_q == TW'(TIMEOUT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Progress on the core handshake wins over a timeout hit in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (any_c) state_d = GRANT;
            GRANT:     state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (core_busy_i)       state_d = RUN;
                       else if (timeout_c)    state_d = IDLE;
            RUN:       if (!core_busy_i)      state_d = RELEASE;
                       else if (timeout_c)    state_d = IDLE;
            RELEASE:   state_d = CAPTURE;
            CAPTURE:   if (core_valid_i)      state_d = RESP;
                       else if (timeout_c)    state_d = IDLE;
            RESP:      if (resp_ready_i)      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        ready_d      = '0;
        core_req_d   = 1'b0;
        resp_valid_d = 1'b0;
        if (state_d == GRANT) ready_d[win_c] = 1'b1;
        if ((state_d == START) || (state_d == RELEASE)) core_req_d = 1'b1;
        if (state_d == RESP) resp_valid_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_ready_o  <= '0;
            core_req_o   <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_id_o    <= '0;
            core_data_o  <= '0;
            err_o        <= 1'b0;
            rr_q         <= '0;
            win_q        <= '0;
            timer_q      <= '0;
        end else begin
            req_ready_o  <= ready_d;
            core_req_o   <= core_req_d;
            resp_valid_o <= resp_valid_d;
            if ((state_q == IDLE) && any_c) win_q <= win_c;
            if (state_q == GRANT) begin
                core_data_o <= req_data_i[{win_q, 7'd0} +: BW];
                rr_q        <= (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
            end
            if ((state_q == CAPTURE) && core_valid_i) begin
                resp_data_o <= core_data_i;
                resp_id_o   <= win_q;
            end
            if (timeout_c) err_o <= 1'b1;
            // Timer restarts on every state change and saturates at TIMEOUT.
            if (state_d != state_q)
                timer_q <= '0;
            else if (waiting_c && (timer_q != TW'(TIMEOUT)))
                timer_q <= timer_q + TW'(1);
        end
    end

endmodule

// File: tb/tb_kuznechik_arbiter.sv
// Scoreboard bench for kuznechik_arbiter with a behavioural cipher-core stub.
module tb_kuznechik_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 255;
    localparam logic [127:0] PT_GOST = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT_GOST = 128'h7f679d90bebc24305a468d42b9d4edcd;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [128*N-1:0] req_data;
    logic             resp_valid;
    logic             resp_ready;
    logic [127:0]     resp_data;
    logic [1:0]       resp_id;
    logic             err;
    logic             core_req;
    logic             core_ack;
    logic [127:0]     core_data;
    logic             core_busy;
    logic             core_valid;
    logic [127:0]     core_dout;

    kuznechik_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_id_o(resp_id), .err_o(err),
        .core_req_o(core_req), .core_ack_o(core_ack), .core_data_o(core_data),
        .core_busy_i(core_busy), .core_valid_i(core_valid), .core_data_i(core_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   id;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_grant_cyc = 0;
    int   resp_rise_cyc = 0;
    int   resp_cnt = 0;
    int   creq_cnt = 0;
    int   busy_len = 12;
    bit   dead = 1'b0;
    bit   hold = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] core_f(input logic [127:0] p);
        if (p == PT_GOST) return CT_GOST;
        return {p[63:0], p[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    // Core stub: START latches data and raises busy for busy_len cycles; RELEASE yields result.
    logic [127:0] core_lat;
    logic         core_done;
    int           core_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy <= 1'b0; core_valid <= 1'b0; core_dout <= '0;
            core_done <= 1'b0; core_cnt <= 0; core_lat <= '0;
        end else begin
            core_valid <= 1'b0;
            if (core_busy) begin
                if (core_cnt == 0) begin core_busy <= 1'b0; core_done <= 1'b1; end
                else core_cnt <= core_cnt - 1;
            end else if (core_done) begin
                if (core_req) begin
                    core_done  <= 1'b0;
                    core_valid <= 1'b1;
                    core_dout  <= core_f(core_lat);
                end
            end else if (core_req && !dead) begin
                core_busy <= 1'b1;
                core_cnt  <= busy_len - 1;
                core_lat  <= core_data;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0] prev_ready = '0;
    logic         prev_creq = 1'b0;
    logic         prev_rv = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                chk("ready_onehot", 128'($onehot(req_ready)), 1);
                chk("ready_pulse", prev_ready, 0);
                for (int k = 0; k < int'(N); k++) if (req_ready[k]) grant_q.push_back(k);
                last_grant_cyc = cyc;
            end
            if (core_req) begin
                chk("core_req_pulse", prev_creq, 0);
                creq_cnt++;
            end
            if (resp_valid && !prev_rv) resp_rise_cyc = cyc;
            if (resp_valid && resp_ready) begin
                chk("resp_queued", 128'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_data", resp_data, e.data);
                end
                resp_cnt++;
            end
        end
        prev_ready = req_ready;
        prev_creq  = core_req;
        prev_rv    = resp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold) req_valid = req_valid & ~req_ready;
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.id   = 2'(k);
        e.data = core_f(req_data[k*128 +: 128]);
        exp_q.push_back(e);
    endtask

    task automatic wait_resps(input int n, input int budget);
        int t = 0;
        while (resp_cnt < n && t < budget) begin tick(); t++; end
        chk("wait_resp", resp_cnt, n);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int t = 0;
        while (grant_q.size() < n && t < budget) begin tick(); t++; end
        chk("wait_grant", grant_q.size(), n);
    endtask

    task automatic chk_rst_vals(input string t);
        chk({t, "_ready"}, req_ready, 0);
        chk({t, "_rvalid"}, resp_valid, 0);
        chk({t, "_rdata"}, resp_data, 0);
        chk({t, "_rid"}, resp_id, 0);
        chk({t, "_err"}, err, 0);
        chk({t, "_creq"}, core_req, 0);
        chk({t, "_cdata"}, core_data, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int r0, g0, c0, gcyc, ecyc, t;
        logic [127:0] d0;
        logic [1:0]   i0;
        int order2[5] = '{0, 1, 2, 3, 0};
        int order6[3] = '{1, 0, 1};

        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        req_data[0*128 +: 128] = 128'h000102030405060708090a0b0c0d0e0f;
        req_data[1*128 +: 128] = 128'hdeadbeefcafef00d0123456789abcdef;
        req_data[2*128 +: 128] = PT_GOST;
        req_data[3*128 +: 128] = 128'h55aa55aa0f0f0f0f3c3c3c3c96969696;
        repeat (3) @(posedge clk);
        #1;
        chk_rst_vals("reset");
        chk("core_ack", core_ack, 0);
        rst = 1'b0;
        tick();

        // Single request from requester 2 (GOST vector)
        r0 = resp_cnt; c0 = creq_cnt;
        push_exp(2);
        req_valid[2] = 1'b1;
        wait_resps(r0 + 1, 200);
        chk("t1_grant", grant_q[0], 2);
        chk("t1_core_pulses", creq_cnt - c0, 2);
        chk("t1_latency", resp_rise_cyc - last_grant_cyc, busy_len + 5);

        // All requesters held from reset: rotation 0,1,2,3,0
        pulse_reset();
        grant_q.delete();
        r0 = resp_cnt;
        foreach (order2[i]) push_exp(order2[i]);
        hold = 1'b1;
        req_valid = '1;
        wait_grants(5, 400);
        req_valid = '0;
        hold = 1'b0;
        wait_resps(r0 + 5, 200);
        foreach (order2[i]) chk("t2_order", grant_q[i], order2[i]);

        // Backpressure: response held 20 cycles, pending request must wait
        r0 = resp_cnt;
        resp_ready = 1'b0;
        push_exp(1);
        req_valid[1] = 1'b1;
        t = 0;
        while (!resp_valid && t < 100) begin tick(); t++; end
        chk("t3_rvalid", resp_valid, 1);
        chk("t3_id", resp_id, 1);
        d0 = resp_data; i0 = resp_id;
        push_exp(3);
        req_valid[3] = 1'b1;
        repeat (20) begin
            tick();
            chk("t3_data_stable", resp_data, d0);
            chk("t3_id_stable", resp_id, i0);
            chk("t3_quiet", {resp_valid, core_req, req_ready}, 6'b100000);
        end
        resp_ready = 1'b1;
        tick();
        chk("t3_idle", {resp_valid, req_ready}, 0);
        tick();
        chk("t3_next_grant", req_ready, 4'b1000);
        wait_resps(r0 + 2, 200);

        // Timeout: core never goes busy
        r0 = resp_cnt;
        dead = 1'b1;
        g0 = grant_q.size();
        req_valid[0] = 1'b1;
        wait_grants(g0 + 1, 100);
        chk("t4_grant", grant_q[g0], 0);
        gcyc = last_grant_cyc;
        t = 0; ecyc = 0;
        while (!err && t < 400) begin tick(); t++; end
        ecyc = cyc;
        chk("t4_err", err, 1);
        chk("t4_err_cycle", ecyc - gcyc, TO + 3);
        chk("t4_no_resp", resp_cnt, r0);
        dead = 1'b0;
        push_exp(2);
        req_valid[2] = 1'b1;
        wait_resps(r0 + 1, 200);
        chk("t4_err_sticky", err, 1);

        // Reset in the middle of RUN
        busy_len = 40;
        g0 = grant_q.size();
        req_valid[1] = 1'b1;
        wait_grants(g0 + 1, 100);
        repeat (10) tick();
        chk("t5_busy", core_busy, 1);
        rst = 1'b1;
        #1;
        chk_rst_vals("t5");
        tick();
        rst = 1'b0;
        busy_len = 12;
        tick();

        // Pointer after serving requester 1 sits at 2: scan 2,3,0 picks 0
        grant_q.delete();
        r0 = resp_cnt;
        push_exp(1);
        req_valid[1] = 1'b1;
        wait_resps(r0 + 1, 200);
        push_exp(0);
        push_exp(1);
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        wait_resps(r0 + 3, 400);
        foreach (order6[i]) chk("t6_order", grant_q[i], order6[i]);
        chk("t6_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
